// File: rtl/pcpi_result_nibble_tx_if.sv
// Signal bundle between the PCPI result source, the nibble transmitter and the off-chip host pins.
interface pcpi_result_nibble_tx_if #(
   parameter int DATA_W = 32,
   parameter int NIB_W  = 4
);
   logic              pcpi_ready;
   logic              pcpi_wr;
   logic [DATA_W-1:0] pcpi_rd;
   logic              host_ack;
   logic              tx_valid;
   logic [NIB_W-1:0]  tx_nibble;
   logic              tx_last;
   logic              busy;
   logic              overrun;

   modport master (
      output pcpi_ready, pcpi_wr, pcpi_rd, host_ack,
      input  tx_valid, tx_nibble, tx_last, busy, overrun
   );

   modport slave (
      input  pcpi_ready, pcpi_wr, pcpi_rd, host_ack,
      output tx_valid, tx_nibble, tx_last, busy, overrun
   );
endinterface

// File: rtl/pcpi_result_nibble_tx.sv
// Captures a PCPI write-back result and ships it LSB-nibble first over a four-phase valid/ack link.
module pcpi_result_nibble_tx #(
   parameter int DATA_W      = 32,
   parameter int NIB_W       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pcpi_result_nibble_tx_if.slave bus,
   output logic [1:0]           dbg_state
);
   localparam int NUM_NIB = DATA_W / NIB_W;
   localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;

   // Handshake: tx_valid rises with a stable nibble; the host raises host_ack once it has
   // taken it; tx_valid then falls; the host drops host_ack; only then may the next nibble appear.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      PRESENT = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [DATA_W-1:0]      data_q;
   logic [IDX_W-1:0]       idx;
   logic                   overrun_q;
   logic                   ack_s;
   logic                   capture;
   logic                   last_idx;

   assign ack_s    = sync_q[SYNC_STAGES-1];
   assign capture  = bus.pcpi_ready && bus.pcpi_wr;
   assign last_idx = (idx == IDX_W'(NUM_NIB - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (capture) state_nxt = ARM;
         ARM:     if (!ack_s)  state_nxt = PRESENT;
         PRESENT: if (ack_s)   state_nxt = RELEASE;
         RELEASE: if (!ack_s)  state_nxt = last_idx ? IDLE : PRESENT;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.tx_valid  = (state == PRESENT);
      bus.tx_last   = (state == PRESENT) && last_idx;
      bus.busy      = (state != IDLE);
      bus.overrun   = overrun_q;
      bus.tx_nibble = data_q[int'(idx)*NIB_W +: NIB_W];
      dbg_state     = state;
   end

   // A capture seen outside IDLE, including the cycle RELEASE hands back to IDLE, is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q    <= '0;
         data_q    <= '0;
         idx       <= '0;
         overrun_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.host_ack};
         if (state == IDLE && capture) begin
            data_q <= bus.pcpi_rd;
            idx    <= '0;
         end
         if (state == RELEASE && !ack_s && !last_idx) idx <= idx + 1'b1;
         if (state != IDLE && capture) overrun_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_pcpi_result_nibble_tx.sv
// Bench for pcpi_result_nibble_tx: vector table of captured words plus hand-written corner sequences.
module tb_pcpi_result_nibble_tx;
   localparam int DATA_W  = 32;
   localparam int NIB_W   = 4;
   localparam int NUM_NIB = DATA_W / NIB_W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] dbg_state;

   pcpi_result_nibble_tx_if #(.DATA_W(DATA_W), .NIB_W(NIB_W)) bus ();

   pcpi_result_nibble_tx #(.DATA_W(DATA_W), .NIB_W(NIB_W), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // {tx_last, tx_nibble} expected at each rising tx_valid
   logic [NIB_W:0] exp_q[$];
   int checks   = 0;
   int failures = 0;
   logic host_auto  = 1'b0;
   logic prev_valid = 1'b0;

   typedef struct {
      logic [DATA_W-1:0] rd;
      logic              wr;
      logic              exp_busy;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [DATA_W-1:0] w);
      logic [DATA_W-1:0] tmp;
      tmp = w;
      for (int k = 0; k < NUM_NIB; k++) begin
         exp_q.push_back({(k == NUM_NIB - 1), tmp[NIB_W-1:0]});
         tmp = tmp >> NIB_W;
      end
   endtask

   task automatic sample();
      logic [NIB_W:0] e;
      if (bus.tx_valid && !prev_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_nibble actual=0x%0h required=none", bus.tx_nibble);
         end else begin
            e = exp_q.pop_front();
            check("nibble_last", {27'd0, bus.tx_last, bus.tx_nibble}, {27'd0, e});
         end
      end
      prev_valid = bus.tx_valid;
      if (host_auto) bus.host_ack = bus.tx_valid;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         sample();
      end
   endtask

   task automatic capture(input logic [DATA_W-1:0] rd, input logic wr);
      bus.pcpi_ready = 1'b1;
      bus.pcpi_wr    = wr;
      bus.pcpi_rd    = rd;
      step(1);
      bus.pcpi_ready = 1'b0;
      bus.pcpi_wr    = 1'b0;
      bus.pcpi_rd    = '0;
   endtask

   task automatic drain(input string name, input int budget);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || bus.busy) && c < budget) begin
         step(1);
         c++;
      end
      check(name, {31'd0, (c < budget)}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_valid"}, {31'd0, bus.tx_valid}, 32'd0);
      check({tag, "_tx_last"},  {31'd0, bus.tx_last},  32'd0);
      check({tag, "_busy"},     {31'd0, bus.busy},     32'd0);
      check({tag, "_overrun"},  {31'd0, bus.overrun},  32'd0);
      check({tag, "_tx_nibble"}, {28'd0, bus.tx_nibble}, 32'd0);
      check({tag, "_state"},    {30'd0, dbg_state},    32'd0);
   endtask

   initial begin
      int c;
      vecs[0] = '{rd: 32'hDEADBEEF, wr: 1'b1, exp_busy: 1'b1};
      vecs[1] = '{rd: 32'h12345678, wr: 1'b0, exp_busy: 1'b0};
      vecs[2] = '{rd: 32'h00000000, wr: 1'b1, exp_busy: 1'b1};
      vecs[3] = '{rd: 32'hFFFFFFFF, wr: 1'b1, exp_busy: 1'b1};
      vecs[4] = '{rd: 32'hA5C30F96, wr: 1'b1, exp_busy: 1'b1};
      vecs[5] = '{rd: $urandom, wr: 1'b1, exp_busy: 1'b1};

      bus.pcpi_ready = 1'b0;
      bus.pcpi_wr    = 1'b0;
      bus.pcpi_rd    = '0;
      bus.host_ack   = 1'b1;

      // reset held 3 cycles with a stale host ack
      rst_n = 1'b0;
      @(negedge clk);
      step(3);
      check_reset_outputs("reset");
      bus.host_ack = 1'b0;
      rst_n = 1'b1;
      step(3);

      // vector table
      host_auto = 1'b1;
      foreach (vecs[i]) begin
         if (vecs[i].wr) push_word(vecs[i].rd);
         capture(vecs[i].rd, vecs[i].wr);
         check("busy_after_capture", {31'd0, bus.busy}, {31'd0, vecs[i].exp_busy});
         if (vecs[i].wr) begin
            step(1);
            check("first_valid_latency", {31'd0, bus.tx_valid}, 32'd1);
            drain("word_drain", 200);
         end else begin
            step(5);
            check("nowr_busy", {31'd0, bus.busy}, 32'd0);
            check("nowr_valid", {31'd0, bus.tx_valid}, 32'd0);
         end
         step(2);
      end
      check("overrun_clean", {31'd0, bus.overrun}, 32'd0);

      // overrun: second capture mid-transfer is dropped
      push_word(32'h0000000F);
      capture(32'h0000000F, 1'b1);
      step(10);
      capture(32'hFFFFFFFF, 1'b1);
      check("overrun_set", {31'd0, bus.overrun}, 32'd1);
      drain("overrun_drain", 200);
      step(4);
      check("overrun_sticky", {31'd0, bus.overrun}, 32'd1);
      check("overrun_idle", {31'd0, bus.busy}, 32'd0);

      // stale ack: host_ack high when the word is captured
      host_auto = 1'b0;
      bus.host_ack = 1'b1;
      step(4);
      push_word(32'h89ABCDEF);
      capture(32'h89ABCDEF, 1'b1);
      step(6);
      check("stale_hold_valid", {31'd0, bus.tx_valid}, 32'd0);
      check("stale_hold_state", {30'd0, dbg_state}, 32'd1);
      bus.host_ack = 1'b0;
      host_auto = 1'b1;
      step(2);
      check("stale_release_early", {31'd0, bus.tx_valid}, 32'd0);
      step(1);
      check("stale_release_valid", {31'd0, bus.tx_valid}, 32'd1);
      drain("stale_drain", 200);
      step(2);

      // reset mid-transfer, then a fresh word starts from index 0
      push_word(32'hCAFEF00D);
      capture(32'hCAFEF00D, 1'b1);
      c = 0;
      while (exp_q.size() > NUM_NIB - 3 && c < 200) begin
         step(1);
         c++;
      end
      check("mid_reach_nibble3", {31'd0, (c < 200)}, 32'd1);
      host_auto = 1'b0;
      bus.host_ack = 1'b0;
      rst_n = 1'b0;
      step(1);
      check_reset_outputs("midreset");
      exp_q.delete();
      rst_n = 1'b1;
      step(2);
      host_auto = 1'b1;
      push_word(32'h76543210);
      capture(32'h76543210, 1'b1);
      drain("fresh_drain", 200);
      step(4);
      check("fresh_idle", {31'd0, bus.busy}, 32'd0);
      check("fresh_no_valid", {31'd0, bus.tx_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
